shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Iterative multi-cycle shift/rotate unit that produces the shifted operand consumed by the ALU as its shift (os=101) and rotate (os=110) source.
- Sits between operand fetch and the ALU. Takes sr1 and a shift amount, shifts STEP bits per cycle, and presents a stable result with a one-cycle done pulse.
- Replaces a single-cycle barrel shifter to save area.

Parameters:
- STEP, 1, bits shifted per RUN cycle. Legal values are 1, 2, 4, 8; any other value is a synthesis error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) immediately forces reset state; it releases synchronously to clk.
- start  in  1  request; sampled only in IDLE or DONE.
- sr1  in  32  operand to shift.
- shamt  in  5  shift amount, 0..31.
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  shifted value, held until next accepted start.
- zero  out  1  result == 0, registered with result.

Behaviour:
- Reset (reset=0): state=IDLE; busy=0, done=0, result=0, zero=1; internal count=0, mode latch=00.
- FSM states and transitions:
  - IDLE: start=1 → latch sr1 into the work register, count=shamt, mode latched → RUN.
  - RUN, count==0 → DONE: result<=work, zero<=(work==0).
  - RUN, count!=0 → shift work by n=min(count,STEP), count-=n, stay in RUN.
  - DONE: done=1 for exactly this cycle.
    - start=1 → accept as in IDLE → RUN (back-to-back).
    - otherwise → IDLE.
- Shift rules, per step of n bits, 32-bit wide:
  - SLL: zero fill from the right.
  - SRL: zero fill from the left.
  - SRA: fill with the bit 31 latched at accept (sign preserved across all steps).
  - ROR: bits leaving bit 0 re-enter at bit 31.
- Latency: with k=ceil(shamt/STEP), done is high after rising edge k+1 counted from the accepting edge (edge 0).
  - shamt=0: done after edge 1, result=sr1.
  - STEP=1, shamt=31: done after edge 32.
- busy=1 exactly in RUN. start while busy is ignored (no queueing). sr1/shamt/mode changes during RUN have no effect.
- result and zero change only on the RUN→DONE edge. They hold through IDLE and through a following RUN.
- Reset asserted mid-RUN: the operation is aborted and all outputs take reset values. done must never fire for an aborted operation.
- No X propagation: mode values are fully decoded.

Decomposition:
- Shared package holds:
  - the mode encodings (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11);
  - the state encodings (IDLE, RUN, DONE);
  - width constants (DATA_W=32, SHAMT_W=5).
- One natural sub-module: shift_step. It is combinational: work, n (0..STEP), mode, and sign in; next work out. The FSM, counter and output registers stay in shift_seq.

Test Plan:
- STEP=1, sr1=0x00000001, shamt=31, SLL → busy high for 32 cycles, done after edge 32, result=0x80000000, zero=0.
- STEP=4, sr1=0x80000000, shamt=4, SRA → done after edge 2, result=0xF8000000. Same with SRL → 0x08000000.
- STEP=4, sr1=0x12345678, shamt=8, ROR → result=0x78123456. shamt=0 with sr1=0xDEADBEEF → done after edge 1, result=0xDEADBEEF.
- STEP=1, sr1=0x00000001, shamt=1, SRL → result=0, zero=1. Then start=1 during the DONE cycle with sr1=0x1, shamt=2, SLL → accepted back-to-back, result=0x4.
- Pulse start with sr1=0x1, shamt=3, SLL, then raise start again mid-RUN with different operands → ignored, result=0x8, exactly one done pulse.
- Drive reset=0 asynchronously mid-RUN → busy=0, done=0, result=0, zero=1 immediately. After release, no done pulse until a new start.

Source files
------------

// File: rtl/shift_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_seq_pkg
// Purpose  : Shared encodings and widths for the iterative shift/rotate unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package shift_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    // Operation select, as presented on mode_i
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
//------------------------------------------------------------------------------
// Module   : shift_step
// Purpose  : One combinational shift/rotate step of 0..STEP bit positions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_step
    import shift_seq_pkg::*;
#(
    parameter int STEP = 1,
    parameter int NW   = $clog2(STEP) + 1
) (
    input  logic [DATA_W-1:0] work_i,
    input  logic [NW-1:0]     n_i,
    input  logic [1:0]        mode_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] work_o
);

    // Apply one step; SRA fills from the sign captured at accept, not the
    // current bit 31, so the sign survives every partial step.
    always_comb begin
        work_o = work_i;
        case (mode_i)
            SHIFT_SLL: work_o = work_i << n_i;
            SHIFT_SRL: work_o = work_i >> n_i;
            SHIFT_SRA: work_o = DATA_W'($signed({sign_i, work_i}) >>> n_i);
            SHIFT_ROR: work_o = (work_i >> n_i) | (work_i << (7'(DATA_W) - 7'(n_i)));
            default:   work_o = work_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
//------------------------------------------------------------------------------
// Module   : shift_seq
// Purpose  : Iterative multi-cycle shift/rotate unit feeding the ALU shift and
//            rotate source. Shifts STEP bits per RUN cycle, then presents a
//            held result with a one-cycle done pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   sr1_i,
    input  logic [SHAMT_W-1:0]  shamt_i,
    input  logic [1:0]          mode_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   result_o,
    output logic                zero_o
);

    localparam int NW = $clog2(STEP) + 1;

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
            $error("shift_seq: STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic               sign_q, sign_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;

    logic [NW-1:0]      w_n;
    logic [DATA_W-1:0]  w_step_out;

    // Step size for this cycle: the remaining count, capped at STEP
    always_comb begin
        if (count_q > SHAMT_W'(STEP)) begin
            w_n = NW'(STEP);
        end else begin
            w_n = count_q[NW-1:0];
        end
    end

    shift_step #(
        .STEP (STEP),
        .NW   (NW)
    ) u_shift_step (
        .work_i (work_q),
        .n_i    (w_n),
        .mode_i (mode_q),
        .sign_i (sign_q),
        .work_o (w_step_out)
    );

    // Sequencer next-state: accept in IDLE/DONE, iterate in RUN, publish on exit
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    work_d  = sr1_i;
                    count_d = shamt_i;
                    mode_d  = mode_i;
                    sign_d  = sr1_i[DATA_W-1];
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_q == '0) begin
                    result_d = work_q;
                    zero_d   = (work_q == '0);
                    state_d  = ST_DONE;
                end else begin
                    work_d  = w_step_out;
                    count_d = count_q - SHAMT_W'(w_n);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            count_q  <= '0;
            mode_q   <= SHIFT_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_seq
// Purpose  : Self-checking bench for shift_seq, exercising STEP=1 and STEP=4
//            instances side by side against an arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_seq;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [31:0]       sr1;
    logic [4:0]        shamt;
    logic [1:0]        mode;
    logic [1:0]        busy_v;
    logic [1:0]        done_v;
    logic [1:0]        zero_v;
    logic [1:0][31:0]  res_v;
    logic [31:0]       prev_res [2];

    int checks = 0;
    int errors = 0;

    shift_seq #(.STEP(1)) u_dut_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .sr1_i    (sr1),
        .shamt_i  (shamt),
        .mode_i   (mode),
        .busy_o   (busy_v[0]),
        .done_o   (done_v[0]),
        .result_o (res_v[0]),
        .zero_o   (zero_v[0])
    );

    shift_seq #(.STEP(4)) u_dut_s4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .sr1_i    (sr1),
        .shamt_i  (shamt),
        .mode_i   (mode),
        .busy_o   (busy_v[1]),
        .done_o   (done_v[1]),
        .result_o (res_v[1]),
        .zero_o   (zero_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Reference: whole-operand shift computed in one go
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic [1:0] md);
        logic signed [31:0] s;
        s = a;
        case (md)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return s >>> sh;
            default: return (a >> sh) | (a << (32 - int'(sh)));
        endcase
    endfunction

    task automatic chk1(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[step=%0d] observed=%b expected=%b", tag, step_of(i), obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[step=%0d] observed=%h expected=%h", tag, step_of(i), obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly the accepting edge
    task automatic accept(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md);
        sr1   = a;
        shamt = sh;
        mode  = md;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Watch cycles first..last after the accepting edge on both instances
    task automatic monitor(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md,
                           input int first, input int last);
        logic [31:0] exp;
        int          lat [2];
        exp = ref_shift(a, sh, md);
        for (int i = 0; i < 2; i++) lat[i] = (int'(sh) + step_of(i) - 1) / step_of(i) + 1;
        for (int c = first; c <= last; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                chk1("busy", i, busy_v[i], c < lat[i]);
                chk1("done", i, done_v[i], c == lat[i]);
                if (c < lat[i]) begin
                    chk32("result_hold", i, res_v[i], prev_res[i]);
                end else begin
                    chk32("result", i, res_v[i], exp);
                    chk1("zero", i, zero_v[i], exp == 32'h0);
                end
            end
        end
        for (int i = 0; i < 2; i++) if (last >= lat[i]) prev_res[i] = exp;
    endtask

    task automatic full_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md);
        accept(a, sh, md);
        monitor(a, sh, md, 1, int'(sh) + 2);
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [1:0]  rm;

        rst_n = 1'b0;
        start = 1'b0;
        sr1   = '0;
        shamt = '0;
        mode  = '0;
        prev_res[0] = '0;
        prev_res[1] = '0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk1("rst_busy", i, busy_v[i], 1'b0);
            chk1("rst_done", i, done_v[i], 1'b0);
            chk32("rst_result", i, res_v[i], 32'h0);
            chk1("rst_zero", i, zero_v[i], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Longest single-bit walk
        full_op(32'h0000_0001, 5'd31, 2'b00);
        chk32("plan_sll31", 0, res_v[0], 32'h8000_0000);

        // Sign fill versus zero fill
        full_op(32'h8000_0000, 5'd4, 2'b10);
        chk32("plan_sra4", 1, res_v[1], 32'hF800_0000);
        full_op(32'h8000_0000, 5'd4, 2'b01);
        chk32("plan_srl4", 1, res_v[1], 32'h0800_0000);

        // Rotate, and zero shift amount
        full_op(32'h1234_5678, 5'd8, 2'b11);
        chk32("plan_ror8", 1, res_v[1], 32'h7812_3456);
        full_op(32'hDEAD_BEEF, 5'd0, 2'b11);
        chk32("plan_sh0", 1, res_v[1], 32'hDEAD_BEEF);

        // Result zero, then back-to-back accept during DONE
        accept(32'h1, 5'd1, 2'b01);
        monitor(32'h1, 5'd1, 2'b01, 1, 2);
        sr1   = 32'h1;
        shamt = 5'd2;
        mode  = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) chk1("b2b_busy", i, busy_v[i], 1'b1);
        monitor(32'h1, 5'd2, 2'b00, 1, 4);
        chk32("plan_b2b", 0, res_v[0], 32'h4);

        // start raised mid-RUN with other operands must be ignored
        accept(32'h1, 5'd3, 2'b00);
        sr1   = 32'hFFFF_0000;
        shamt = 5'd7;
        mode  = 2'b11;
        start = 1'b1;
        monitor(32'h1, 5'd3, 2'b00, 1, 1);
        start = 1'b0;
        monitor(32'h1, 5'd3, 2'b00, 2, 6);
        chk32("plan_ignore", 0, res_v[0], 32'h8);

        // Asynchronous reset mid-RUN aborts and clears outputs at once
        accept(32'h0000_00F0, 5'd31, 2'b00);
        monitor(32'h0000_00F0, 5'd31, 2'b00, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1("abort_busy", i, busy_v[i], 1'b0);
            chk1("abort_done", i, done_v[i], 1'b0);
            chk32("abort_result", i, res_v[i], 32'h0);
            chk1("abort_zero", i, zero_v[i], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_res[0] = '0;
        prev_res[1] = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                chk1("post_abort_done", i, done_v[i], 1'b0);
                chk1("post_abort_busy", i, busy_v[i], 1'b0);
            end
        end

        // Randomised operations
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            rm = 2'($urandom_range(0, 3));
            full_op(ra, rs, rm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
